// File: rtl/if_stage_pkg.sv
//============================================================================
// if_stage_pkg
//----------------------------------------------------------------------------
// Purpose : Types and constants shared by if_stage and its IF/ID register.
//           Constant values match define.vh.
// Contents: bus widths, reset vector, zero word, ROM enable levels,
//           fetch FSM state type, IF/ID register operation type,
//           word-alignment helper.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

package if_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [INST_W-1:0]      ZERO_WORD    = 32'h0000_0000;
  localparam logic                   CHIP_ENABLE  = 1'b1;
  localparam logic                   CHIP_DISABLE = 1'b0;

  // Fetch sequencer: one BOOT cycle with the ROM disabled, then RUN.
  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // What the IF/ID register does on the next edge.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_e;

  // Instruction addresses are always word aligned.
  function automatic logic [INST_ADDR_W-1:0] word_align(
    input logic [INST_ADDR_W-1:0] addr
  );
    return addr & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/define.vh
//============================================================================
// define.vh
//----------------------------------------------------------------------------
// Purpose : Shared text macros for the fetch path (bus widths, constant
//           words, ROM chip-enable levels, reset vector, stall levels).
//           if_stage_pkg carries the same values as typed localparams for
//           use inside the RTL.
// Revision: 1.0  initial release
//============================================================================
`ifndef IF_STAGE_DEFINE_VH
`define IF_STAGE_DEFINE_VH

`define InstAddrBus  31:0
`define InstBus      31:0
`define ZeroWord     32'h0000_0000
`define ChipEnable   1'b1
`define ChipDisable  1'b0
`define ResetVector  32'h0000_0000
`define Stop         1'b1
`define NoStop       1'b0

`endif

// File: rtl/if_id.sv
//============================================================================
// if_id
//----------------------------------------------------------------------------
// Purpose : IF/ID pipeline register. Holds, bubbles or loads the fetched
//           (pc, instruction) pair as directed by if_stage.
// Ports   : clk       in   clock, rising edge
//           rst       in   synchronous active-low reset
//           op        in   HOLD / BUBBLE / LOAD for the next edge
//           pc        in   32  address of the instruction being fetched
//           inst      in   32  instruction word from ROM
//           id_pc     out  32  registered pc to ID
//           id_inst   out  32  registered instruction to ID
//           id_valid  out  1   registered valid to ID
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

module if_id
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  ifid_op_e               op,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic [INST_W-1:0]      inst,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_pc    <= '0;
      id_inst  <= ZERO_WORD;
      id_valid <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          id_pc    <= pc;
          id_inst  <= inst;
          id_valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          id_pc    <= '0;
          id_inst  <= ZERO_WORD;
          id_valid <= 1'b0;
        end
        default: begin
          // hold
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//============================================================================
// if_stage
//----------------------------------------------------------------------------
// Purpose : Instruction fetch stage. BOOT->RUN sequencer, program counter
//           with single-delay-slot branch redirect, fetch counter, and the
//           IF/ID register (sub-module if_id).
// Config  : define IF_EXCEPTION_EN to add flush_i/new_pc_i, an exception
//           redirect that overrides stalls and branches.
// Ports   : clk              in   clock, rising edge
//           rst              in   synchronous active-low reset
//           stall_if         in   hold PC, bubble IF/ID
//           stall_id         in   hold IF/ID
//           branch_flag_i    in   taken branch/jump resolved in ID
//           branch_target_i  in   32  branch/jump target
//           flush_i          in   exception redirect (IF_EXCEPTION_EN)
//           new_pc_i         in   32  redirect address (IF_EXCEPTION_EN)
//           rom_ce_o         out  instruction ROM chip enable
//           pc_o             out  32  ROM byte address
//           inst_i           in   32  ROM data (combinational from pc_o)
//           id_pc_o          out  32  IF/ID pc
//           id_inst_o        out  32  IF/ID instruction
//           id_valid_o       out  IF/ID valid
//           fetch_cnt_o      out  32  instructions accepted into IF/ID
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

module if_stage
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
`ifdef IF_EXCEPTION_EN
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] new_pc_i,
`endif
  output logic                   rom_ce_o,
  output logic [INST_ADDR_W-1:0] pc_o,
  input  logic [INST_W-1:0]      inst_i,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  output logic                   id_valid_o,
  output logic [31:0]            fetch_cnt_o
);

  fetch_state_e           state_q;
  fetch_state_e           state_d;
  logic [INST_ADDR_W-1:0] pc_q;
  logic [INST_ADDR_W-1:0] pc_d;
  logic [31:0]            fetch_cnt_q;
  logic                   cnt_inc;
  ifid_op_e               ifid_op;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      fetch_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (cnt_inc) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    // BOOT lasts a single cycle; only reset returns the sequencer to it.
    state_d  = ST_RUN;
    rom_ce_o = CHIP_DISABLE;
    pc_d     = pc_q;
    ifid_op  = IFID_BUBBLE;
    cnt_inc  = 1'b0;

    if (state_q == ST_RUN) begin
      rom_ce_o = CHIP_ENABLE;
      if (stall_id) begin
        ifid_op = IFID_HOLD;
      end else if (!stall_if) begin
        ifid_op = IFID_LOAD;
        cnt_inc = 1'b1;
      end
      // The branch is ignored while IF is stalled; ID keeps asserting it
      // until the stall clears. The current fetch still loads (delay slot).
      if (!stall_if) begin
        pc_d = branch_flag_i ? word_align(branch_target_i) : pc_q + 32'd4;
      end
    end

`ifdef IF_EXCEPTION_EN
    if (flush_i) begin
      pc_d    = word_align(new_pc_i);
      ifid_op = IFID_BUBBLE;
      cnt_inc = 1'b0;
    end
`endif
  end

  assign pc_o        = pc_q;
  assign fetch_cnt_o = fetch_cnt_q;

  if_id u_if_id (
    .clk      (clk),
    .rst      (rst),
    .op       (ifid_op),
    .pc       (pc_q),
    .inst     (inst_i),
    .id_pc    (id_pc_o),
    .id_inst  (id_inst_o),
    .id_valid (id_valid_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//============================================================================
// tb_if_stage
//----------------------------------------------------------------------------
// Purpose : Self-checking bench for if_stage. A behavioural model tracks
//           the expected fetch state; every cycle the outputs are compared
//           against it, and directed scenarios pin literal values.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
`ifdef IF_EXCEPTION_EN
  logic        flush_i;
  logic [31:0] new_pc_i;
`endif
  logic        rom_ce_o;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic [31:0] fetch_cnt_o;

  // Instruction ROM contents: a fixed scramble of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign inst_i = rom(pc_o);

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
`ifdef IF_EXCEPTION_EN
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
`endif
    .rom_ce_o        (rom_ce_o),
    .pc_o            (pc_o),
    .inst_i          (inst_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o),
    .fetch_cnt_o     (fetch_cnt_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_known = 1'b0;
  logic        m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_idpc;
  logic [31:0] m_idinst;
  logic        m_valid;
  logic [31:0] m_cnt;
  logic        m_flush;

  always @(posedge clk) begin
    if (!rst) begin
      m_known  = 1'b1;
      m_boot   = 1'b1;
      m_pc     = 32'h0;
      m_idpc   = 32'h0;
      m_idinst = 32'h0;
      m_valid  = 1'b0;
      m_cnt    = 32'h0;
    end else if (m_known) begin
      m_flush = 1'b0;
`ifdef IF_EXCEPTION_EN
      m_flush = flush_i;
`endif
      // IF/ID register
      if (m_flush || m_boot || (!stall_id && stall_if)) begin
        m_idpc   = 32'h0;
        m_idinst = 32'h0;
        m_valid  = 1'b0;
      end else if (!stall_id) begin
        m_idpc   = m_pc;
        m_idinst = rom(m_pc);
        m_valid  = 1'b1;
        m_cnt    = m_cnt + 32'd1;
      end
      // program counter
      if (m_flush) begin
`ifdef IF_EXCEPTION_EN
        m_pc = {new_pc_i[31:2], 2'b00};
`endif
      end else if (!m_boot && !stall_if) begin
        if (branch_flag_i) m_pc = {branch_target_i[31:2], 2'b00};
        else               m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("rom_ce",    {31'h0, rom_ce_o},   {31'h0, ~m_boot});
      chk("pc",        pc_o,                m_pc);
      chk("id_pc",     id_pc_o,             m_idpc);
      chk("id_inst",   id_inst_o,           m_idinst);
      chk("id_valid",  {31'h0, id_valid_o}, {31'h0, m_valid});
      chk("fetch_cnt", fetch_cnt_o,         m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic lit(input logic [31:0] pc_e, input logic [31:0] idpc_e,
                     input logic v_e, input logic [31:0] cnt_e);
    chk("lit_pc",     pc_o,                pc_e);
    chk("lit_id_pc",  id_pc_o,             idpc_e);
    chk("lit_valid",  {31'h0, id_valid_o}, {31'h0, v_e});
    chk("lit_cnt",    fetch_cnt_o,         cnt_e);
  endtask

  initial begin
    rst             = 1'b0;
    stall_if        = 1'b0;
    stall_id        = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
`ifdef IF_EXCEPTION_EN
    flush_i         = 1'b0;
    new_pc_i        = 32'h0;
`endif
    // reset for three edges, then BOOT
    repeat (3) nxt();
    chk("boot_ce", {31'h0, rom_ce_o}, 32'h0);
    lit(32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    nxt();
    chk("run_ce", {31'h0, rom_ce_o}, 32'h1);
    lit(32'h0, 32'h0, 1'b0, 32'h0);
    nxt(); lit(32'h4, 32'h0, 1'b1, 32'd1);
    chk("first_inst", id_inst_o, rom(32'h0));
    nxt(); lit(32'h8, 32'h4, 1'b1, 32'd2);
    nxt(); lit(32'hC, 32'h8, 1'b1, 32'd3);
    nxt(); nxt(); lit(32'h14, 32'h10, 1'b1, 32'd5);
    // branch with delay slot, target low bits dropped
    branch_flag_i = 1'b1; branch_target_i = 32'h103;
    nxt(); lit(32'h100, 32'h14, 1'b1, 32'd6);
    branch_flag_i = 1'b0;
    nxt(); lit(32'h104, 32'h100, 1'b1, 32'd7);
    branch_flag_i = 1'b1; branch_target_i = 32'h20;
    nxt(); lit(32'h20, 32'h104, 1'b1, 32'd8);
    // IF stall: bubbles, PC and counter frozen
    branch_flag_i = 1'b0; stall_if = 1'b1;
    nxt(); lit(32'h20, 32'h0, 1'b0, 32'd8);
    chk("stall_inst1", id_inst_o, 32'h0);
    nxt(); lit(32'h20, 32'h0, 1'b0, 32'd8);
    chk("stall_inst2", id_inst_o, 32'h0);
    stall_if = 1'b0;
    nxt(); lit(32'h24, 32'h20, 1'b1, 32'd9);
    branch_flag_i = 1'b1; branch_target_i = 32'h18;
    nxt(); lit(32'h18, 32'h24, 1'b1, 32'd10);
    branch_flag_i = 1'b0;
    nxt(); lit(32'h1C, 32'h18, 1'b1, 32'd11);
    nxt(); lit(32'h20, 32'h1C, 1'b1, 32'd12);
    // IF and ID stalled: IF/ID holds
    stall_if = 1'b1; stall_id = 1'b1;
    nxt(); lit(32'h20, 32'h1C, 1'b1, 32'd12);
    nxt(); lit(32'h20, 32'h1C, 1'b1, 32'd12);
    chk("hold_inst", id_inst_o, rom(32'h1C));
    stall_if = 1'b0; stall_id = 1'b0;
    nxt(); lit(32'h24, 32'h20, 1'b1, 32'd13);
    // PC wrap at top of address space
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFF;
    nxt(); lit(32'hFFFF_FFFC, 32'h24, 1'b1, 32'd14);
    branch_flag_i = 1'b0;
    nxt(); lit(32'h0, 32'hFFFF_FFFC, 1'b1, 32'd15);
    nxt(); lit(32'h4, 32'h0, 1'b1, 32'd16);
    // reset in the middle of a stall with a branch pending
    stall_if = 1'b1;
    nxt(); lit(32'h4, 32'h0, 1'b0, 32'd16);
    rst = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h400;
    nxt();
    chk("mid_rst_ce", {31'h0, rom_ce_o}, 32'h0);
    lit(32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1; stall_if = 1'b0; branch_flag_i = 1'b0;
    nxt(); nxt(); lit(32'h4, 32'h0, 1'b1, 32'd1);
`ifdef IF_EXCEPTION_EN
    // flush overrides stall_if, stall_id and branch
    flush_i = 1'b1; new_pc_i = 32'h183;
    stall_if = 1'b1; stall_id = 1'b1;
    branch_flag_i = 1'b1; branch_target_i = 32'h40;
    nxt(); lit(32'h180, 32'h0, 1'b0, 32'd1);
    chk("flush_inst", id_inst_o, 32'h0);
    flush_i = 1'b0; stall_if = 1'b0; stall_id = 1'b0; branch_flag_i = 1'b0;
    // reset during a stall with a flush pending
    stall_if = 1'b1; nxt();
    rst = 1'b0; flush_i = 1'b1; nxt();
    lit(32'h0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1; flush_i = 1'b0; stall_if = 1'b0;
`endif
    // randomized phase, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 199) != 0);
      stall_if        = ($urandom_range(0, 3) == 0);
      stall_id        = ($urandom_range(0, 4) == 0);
      branch_flag_i   = ($urandom_range(0, 4) == 0);
      branch_target_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                    : $urandom;
`ifdef IF_EXCEPTION_EN
      flush_i         = ($urandom_range(0, 19) == 0);
      new_pc_i        = $urandom;
`endif
      nxt();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
